// File: rtl/sonar_scheduler.sv
// sonar_scheduler: alternates two HC-SR04 sensors on one shared trigger/echo timing channel
module sonar_scheduler #(
  parameter int TRIG_CYCLES  = 500,
  parameter int ECHO_TIMEOUT = 1_500_000,
  parameter int GAP_CYCLES   = 500_000,
  parameter int DIST_W       = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo_main,
  input  logic              echo_mini,
  output logic              trig_main,
  output logic              trig_mini,
  output logic [DIST_W-1:0] dist_main,
  output logic [DIST_W-1:0] dist_mini,
  output logic              valid_main,
  output logic              valid_mini,
  output logic              timeout_main,
  output logic              timeout_mini,
  output logic              active_sel
);
  localparam int MX = ECHO_TIMEOUT > GAP_CYCLES ? ECHO_TIMEOUT : GAP_CYCLES;
  localparam int CW = $clog2(MX + 1);

  if (64'(ECHO_TIMEOUT) > (64'd1 << DIST_W) - 64'd1) begin : g_range
    $error("ECHO_TIMEOUT does not fit in DIST_W bits");
  end

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  state_t        state, state_n;
  logic [1:0]    sync_main, sync_mini;
  logic          echo_s, echo_d, rise, hit_valid, hit_to, sel_n;
  logic [CW-1:0] cnt;

  assign echo_s = active_sel ? sync_mini[1] : sync_main[1];
  assign rise   = echo_s & ~echo_d;
  assign sel_n  = active_sel ^ (state == GAP && state_n != GAP);

  // next state and measurement outcome; the MEASURE count runs on the delayed echo so dist equals echo width
  always_comb begin
    state_n   = state;
    hit_valid = 1'b0;
    hit_to    = 1'b0;
    case (state)
      IDLE:      if (enable) state_n = TRIG;
      TRIG:      if (cnt == CW'(TRIG_CYCLES - 1)) state_n = WAIT_RISE;
      WAIT_RISE: if (rise) state_n = MEASURE;
                 else if (cnt == CW'(ECHO_TIMEOUT - 1)) begin
                   state_n = GAP;
                   hit_to  = 1'b1;
                 end
      MEASURE:   if (!echo_d) begin
                   state_n   = GAP;
                   hit_valid = 1'b1;
                 end else if (cnt == CW'(ECHO_TIMEOUT)) begin
                   state_n = GAP;
                   hit_to  = 1'b1;
                 end
      GAP:       if (cnt == CW'(GAP_CYCLES - 1)) state_n = enable ? TRIG : IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // state, shared counter, echo synchronizers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sync_main    <= '0;
      sync_mini    <= '0;
      echo_d       <= 1'b0;
      active_sel   <= 1'b0;
      trig_main    <= 1'b0;
      trig_mini    <= 1'b0;
      dist_main    <= '0;
      dist_mini    <= '0;
      valid_main   <= 1'b0;
      valid_mini   <= 1'b0;
      timeout_main <= 1'b0;
      timeout_mini <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      sync_main    <= {sync_main[0], echo_main};
      sync_mini    <= {sync_mini[0], echo_mini};
      echo_d       <= echo_s;
      active_sel   <= sel_n;
      trig_main    <= state_n == TRIG && !sel_n;
      trig_mini    <= state_n == TRIG && sel_n;
      valid_main   <= hit_valid && !active_sel;
      valid_mini   <= hit_valid && active_sel;
      timeout_main <= hit_to && !active_sel;
      timeout_mini <= hit_to && active_sel;
      if (hit_valid && !active_sel) dist_main <= DIST_W'(cnt);
      if (hit_valid && active_sel) dist_mini <= DIST_W'(cnt);
    end
  end
endmodule
